// File: rtl/vending_machine_multi_slot_pkg.sv
// Shared encodings and coin helpers for the multi-slot vending controller.
// The greedy selector assumes balances are always a multiple of 5.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_PAYOUT   = 2'd3
  } state_t;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] COIN_50   = 3'b011;
  localparam logic [2:0] COIN_100  = 3'b100;
  localparam logic [2:0] COIN_500  = 3'b101;

  function automatic logic [9:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5:   return 10'd5;
      COIN_10:  return 10'd10;
      COIN_50:  return 10'd50;
      COIN_100: return 10'd100;
      COIN_500: return 10'd500;
      default:  return 10'd0;
    endcase
  endfunction

  function automatic logic coin_code_valid(input logic [2:0] code);
    return code <= COIN_500;
  endfunction

  function automatic logic [2:0] largest_coin(input logic [31:0] amount);
    if (amount >= 32'd500)     return COIN_500;
    else if (amount >= 32'd100) return COIN_100;
    else if (amount >= 32'd50)  return COIN_50;
    else if (amount >= 32'd10)  return COIN_10;
    else if (amount >= 32'd5)   return COIN_5;
    else                        return COIN_NONE;
  endfunction

endpackage

// File: rtl/vending_machine_multi_slot_if.sv
// Customer, pricing and coin-return signals of the multi-slot vending controller.
interface vending_machine_multi_slot_if #(
  parameter int NUM_SLOTS = 4,
  parameter int BAL_W     = 16
);
  localparam int SEL_W = $clog2(NUM_SLOTS);

  logic [2:0]       coin;
  logic [SEL_W-1:0] sel;
  logic             buy;
  logic             refund;
  logic             mode_select;
  logic             price_wr;
  logic [BAL_W-1:0] price_val;
  logic             restock;

  logic             product;
  logic [SEL_W-1:0] product_slot;
  logic             refund_signal;
  logic             sold_out;
  logic             coin_reject;
  logic [BAL_W-1:0] balance;
  logic [2:0]       change_coin;
  logic             change_valid;
  logic             busy;

  modport master (
    output coin, sel, buy, refund, mode_select, price_wr, price_val, restock,
    input  product, product_slot, refund_signal, sold_out, coin_reject,
           balance, change_coin, change_valid, busy
  );

  modport slave (
    input  coin, sel, buy, refund, mode_select, price_wr, price_val, restock,
    output product, product_slot, refund_signal, sold_out, coin_reject,
           balance, change_coin, change_valid, busy
  );
endinterface

// File: rtl/vending_machine_multi_slot_change_payout.sv
// Greedy change selector: largest coin not exceeding the remaining balance.
module vm_change_payout
  import vm_pkg::*;
#(
  parameter int BAL_W = 16
) (
  input  logic [BAL_W-1:0] remaining,
  output logic [2:0]       coin_code,
  output logic [BAL_W-1:0] coin_val
);
  always_comb begin
    coin_code = largest_coin(32'(remaining));
    coin_val  = BAL_W'(coin_value(coin_code));
  end
endmodule

// File: rtl/vending_machine_multi_slot.sv
// Multi-slot vending controller with manual/auto-bulk selling and greedy coin payout.
// state    | meaning
// IDLE     | no credit, price writes allowed
// COLLECT  | credit held, waiting for buy or refund
// DISPENSE | one item out per cycle, balance and stock debited
// PAYOUT   | one change coin per cycle until balance is 0
module vending_machine_multi_slot
  import vm_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int BAL_W      = 16,
  parameter int BAL_MAX    = 1000,
  parameter int STOCK_W    = 4,
  parameter int PRICE_INIT = 100
) (
  input logic clk,
  input logic reset,
  vending_machine_multi_slot_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SLOTS);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [BAL_W:0]     BAL_LIMIT = (BAL_W+1)'(BAL_MAX);
  localparam logic [BAL_W-1:0]   PRICE_RST = BAL_W'(PRICE_INIT);

  state_t           state;
  logic [BAL_W-1:0] price [NUM_SLOTS];
  logic [STOCK_W-1:0] stock [NUM_SLOTS];
  logic [SEL_W-1:0] slot_q;
  logic [BAL_W-1:0] balance_q;
  logic             product_q, refund_q, sold_out_q, reject_q, change_valid_q, busy_q;
  logic [SEL_W-1:0] product_slot_q;
  logic [2:0]       change_coin_q;

  logic [BAL_W-1:0]   coin_amt, pay_val, disp_price, disp_rem;
  logic [BAL_W:0]     coin_sum;
  logic [2:0]         pay_code;
  logic               coin_present, coin_credit, price_ok;
  logic [STOCK_W-1:0] disp_stock;

  vm_change_payout #(.BAL_W(BAL_W)) u_payout (
    .remaining (balance_q),
    .coin_code (pay_code),
    .coin_val  (pay_val)
  );

  assign coin_amt     = BAL_W'(coin_value(bus.coin));
  assign coin_sum     = {1'b0, balance_q} + {1'b0, coin_amt};
  assign coin_present = bus.coin != COIN_NONE;
  assign coin_credit  = coin_present && coin_code_valid(bus.coin) && (coin_sum <= BAL_LIMIT)
                        && (state == ST_IDLE || state == ST_COLLECT);
  assign price_ok     = (bus.price_val != '0) && ((bus.price_val % BAL_W'(5)) == '0)
                        && ({1'b0, bus.price_val} <= BAL_LIMIT);
  assign disp_price   = price[slot_q];
  assign disp_rem     = balance_q - disp_price;
  // Stock the slot will hold after this dispense, with a same-cycle restock winning.
  assign disp_stock   = (bus.restock && bus.sel == slot_q) ? STOCK_MAX
                        : stock[slot_q] - STOCK_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      slot_q         <= '0;
      balance_q      <= '0;
      product_q      <= 1'b0;
      product_slot_q <= '0;
      refund_q       <= 1'b0;
      sold_out_q     <= 1'b0;
      reject_q       <= 1'b0;
      change_coin_q  <= COIN_NONE;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price[i] <= PRICE_RST;
        stock[i] <= STOCK_MAX;
      end
    end else begin
      product_q      <= 1'b0;
      product_slot_q <= '0;
      refund_q       <= 1'b0;
      sold_out_q     <= 1'b0;
      reject_q       <= coin_present && !coin_credit;
      change_coin_q  <= COIN_NONE;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (coin_credit) begin
            balance_q <= coin_sum[BAL_W-1:0];
            state     <= ST_COLLECT;
          end
          if (bus.price_wr && price_ok) price[bus.sel] <= bus.price_val;
        end
        ST_COLLECT: begin
          if (coin_credit) balance_q <= coin_sum[BAL_W-1:0];
          // Buy is judged on the balance before any coin arriving this cycle.
          if (bus.refund) begin
            refund_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= ST_PAYOUT;
          end else if (bus.buy) begin
            if (stock[bus.sel] == '0) begin
              sold_out_q <= 1'b1;
            end else if (balance_q >= price[bus.sel]) begin
              slot_q <= bus.sel;
              busy_q <= 1'b1;
              state  <= ST_DISPENSE;
            end
          end
        end
        ST_DISPENSE: begin
          product_q      <= 1'b1;
          product_slot_q <= slot_q;
          balance_q      <= disp_rem;
          stock[slot_q]  <= stock[slot_q] - STOCK_W'(1);
          if (!bus.mode_select) begin
            state <= (disp_rem != '0) ? ST_COLLECT : ST_IDLE;
          end else if (disp_rem >= disp_price && disp_stock != '0) begin
            busy_q <= 1'b1;
            state  <= ST_DISPENSE;
          end else if (disp_rem != '0) begin
            busy_q <= 1'b1;
            state  <= ST_PAYOUT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PAYOUT: begin
          if (balance_q != '0) begin
            change_valid_q <= 1'b1;
            change_coin_q  <= pay_code;
            balance_q      <= balance_q - pay_val;
          end
          if (balance_q == pay_val) state <= ST_IDLE;
          else                      busy_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      if (bus.restock) stock[bus.sel] <= STOCK_MAX;
    end
  end

  assign bus.product       = product_q;
  assign bus.product_slot  = product_slot_q;
  assign bus.refund_signal = refund_q;
  assign bus.sold_out      = sold_out_q;
  assign bus.coin_reject   = reject_q;
  assign bus.balance       = balance_q;
  assign bus.change_coin   = change_coin_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_vending_machine_multi_slot.sv
// Bench for the multi-slot vending controller: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the selling rules.
module tb_vending_machine_multi_slot;
  localparam int NS = 4;
  localparam int BW = 16;
  localparam int SMAX = 15;

  localparam int PH_IDLE = 0, PH_CREDIT = 1, PH_VEND = 2, PH_CHANGE = 3;

  logic clk;
  logic reset;

  vending_machine_multi_slot_if #(.NUM_SLOTS(NS), .BAL_W(BW)) vif ();

  vending_machine_multi_slot #(
    .NUM_SLOTS(NS), .BAL_W(BW), .BAL_MAX(1000), .STOCK_W(4), .PRICE_INIT(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bal, m_phase, m_vslot;
  int m_price[NS];
  int m_stock[NS];
  int e_product, e_slot, e_refund, e_sold, e_reject, e_cvalid, e_ccoin, e_busy;
  int denom[5] = '{500, 100, 50, 10, 5};
  int dcode[5] = '{5, 4, 3, 2, 1};

  function automatic int coin_amt(input logic [2:0] c);
    case (c)
      3'd1: return 5;
      3'd2: return 10;
      3'd3: return 50;
      3'd4: return 100;
      3'd5: return 500;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_bal = 0; m_phase = PH_IDLE; m_vslot = 0;
    for (int i = 0; i < NS; i++) begin
      m_price[i] = 100;
      m_stock[i] = SMAX;
    end
    e_product = 0; e_slot = 0; e_refund = 0; e_sold = 0;
    e_reject = 0; e_cvalid = 0; e_ccoin = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int cv, pre, s;
    bit present, credit;
    e_product = 0; e_slot = 0; e_refund = 0; e_sold = 0; e_cvalid = 0; e_ccoin = 0;
    s = int'(vif.sel);
    cv = coin_amt(vif.coin);
    present = vif.coin != 3'd0;
    credit = (m_phase == PH_IDLE || m_phase == PH_CREDIT) && present
             && vif.coin <= 3'd5 && (m_bal + cv <= 1000);
    e_reject = (present && !credit) ? 1 : 0;
    pre = m_bal;
    if (credit) m_bal += cv;
    case (m_phase)
      PH_IDLE: begin
        if (credit) m_phase = PH_CREDIT;
        if (vif.price_wr && vif.price_val != 0 && vif.price_val % 5 == 0 && vif.price_val <= 1000)
          m_price[s] = int'(vif.price_val);
      end
      PH_CREDIT: begin
        if (vif.refund) begin
          e_refund = 1;
          m_phase = PH_CHANGE;
        end else if (vif.buy) begin
          if (m_stock[s] == 0) e_sold = 1;
          else if (pre >= m_price[s]) begin
            m_vslot = s;
            m_phase = PH_VEND;
          end
        end
      end
      PH_VEND: begin
        e_product = 1;
        e_slot = m_vslot;
        m_bal -= m_price[m_vslot];
        m_stock[m_vslot] -= 1;
        if (vif.restock) m_stock[s] = SMAX;
        if (!vif.mode_select) m_phase = (m_bal != 0) ? PH_CREDIT : PH_IDLE;
        else if (m_bal >= m_price[m_vslot] && m_stock[m_vslot] != 0) m_phase = PH_VEND;
        else m_phase = (m_bal != 0) ? PH_CHANGE : PH_IDLE;
      end
      default: begin
        if (m_bal > 0) begin
          for (int k = 0; k < 5; k++) begin
            if (e_cvalid == 0 && denom[k] <= m_bal) begin
              e_cvalid = 1;
              e_ccoin = dcode[k];
              m_bal -= denom[k];
            end
          end
        end
        if (m_bal == 0) m_phase = PH_IDLE;
      end
    endcase
    if (vif.restock) m_stock[s] = SMAX;
    e_busy = (m_phase == PH_VEND || m_phase == PH_CHANGE) ? 1 : 0;
  endtask

  // ---------------- event monitor for directed literals ----------------
  int n_prod, n_sold, n_rej, n_ref, last_slot, cyc;
  int chg_q[$];
  int chg_t[$];

  task automatic clr_mon();
    n_prod = 0; n_sold = 0; n_rej = 0; n_ref = 0; last_slot = -1;
    chg_q.delete();
    chg_t.delete();
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else model_step();
    cyc++;
    #1;
    chk("product", int'(vif.product), e_product);
    if (e_product != 0) chk("product_slot", int'(vif.product_slot), e_slot);
    chk("refund_signal", int'(vif.refund_signal), e_refund);
    chk("sold_out", int'(vif.sold_out), e_sold);
    chk("coin_reject", int'(vif.coin_reject), e_reject);
    chk("balance", int'(vif.balance), m_bal);
    chk("change_valid", int'(vif.change_valid), e_cvalid);
    if (e_cvalid != 0) chk("change_coin", int'(vif.change_coin), e_ccoin);
    chk("busy", int'(vif.busy), e_busy);
    if (vif.product) begin n_prod++; last_slot = int'(vif.product_slot); end
    if (vif.sold_out) n_sold++;
    if (vif.coin_reject) n_rej++;
    if (vif.refund_signal) n_ref++;
    if (vif.change_valid) begin chg_q.push_back(int'(vif.change_coin)); chg_t.push_back(cyc); end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    vif.coin = 3'd0; vif.sel = '0; vif.buy = 1'b0; vif.refund = 1'b0;
    vif.mode_select = 1'b0; vif.price_wr = 1'b0; vif.price_val = '0; vif.restock = 1'b0;
  endtask

  task automatic put_coin(input logic [2:0] c);
    vif.coin = c;
    @(negedge clk);
    vif.coin = 3'd0;
  endtask

  task automatic pulse_buy(input int s);
    vif.sel = s[1:0];
    vif.buy = 1'b1;
    @(negedge clk);
    vif.buy = 1'b0;
  endtask

  task automatic write_price(input int s, input int v);
    vif.sel = s[1:0];
    vif.price_val = v[BW-1:0];
    vif.price_wr = 1'b1;
    @(negedge clk);
    vif.price_wr = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (vif.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("settle_in_budget", (n < 100) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    idle_inputs();
    clr_mon();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_balance", int'(vif.balance), 0);
    chk("rst_busy", int'(vif.busy), 0);
    chk("rst_product", int'(vif.product), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: manual buy, product two edges after buy is sampled
    clr_mon();
    put_coin(3'b100);
    vif.sel = 2'd0; vif.buy = 1'b1;
    @(posedge clk); #2;
    chk("t1_no_product_yet", int'(vif.product), 0);
    @(negedge clk); vif.buy = 1'b0;
    @(posedge clk); #2;
    chk("t1_product", int'(vif.product), 1);
    chk("t1_slot", int'(vif.product_slot), 0);
    chk("t1_balance", int'(vif.balance), 0);
    @(negedge clk);
    settle();
    chk("t1_products", n_prod, 1);
    chk("t1_no_change", chg_q.size(), 0);

    // 2: auto-bulk, 610 at price 200 -> 3 items and one 10 coin
    clr_mon();
    write_price(1, 200);
    put_coin(3'b101); put_coin(3'b100); put_coin(3'b010);
    vif.mode_select = 1'b1;
    pulse_buy(1);
    settle();
    vif.mode_select = 1'b0;
    chk("t2_products", n_prod, 3);
    chk("t2_last_slot", last_slot, 1);
    chk("t2_change_count", chg_q.size(), 1);
    if (chg_q.size() > 0) chk("t2_change0", chg_q[0], 2);
    chk("t2_balance", int'(vif.balance), 0);

    // 3: refund of 65 -> 50,10,5 on consecutive cycles
    clr_mon();
    put_coin(3'b011); put_coin(3'b010); put_coin(3'b001);
    vif.refund = 1'b1; @(negedge clk); vif.refund = 1'b0;
    settle();
    chk("t3_refund_pulses", n_ref, 1);
    chk("t3_change_count", chg_q.size(), 3);
    if (chg_q.size() == 3) begin
      chk("t3_c0", chg_q[0], 3);
      chk("t3_c1", chg_q[1], 2);
      chk("t3_c2", chg_q[2], 1);
      chk("t3_consecutive", chg_t[2] - chg_t[0], 2);
    end
    chk("t3_balance", int'(vif.balance), 0);

    // 4: drain slot 2, sold_out, restock, buy again
    clr_mon();
    write_price(2, 5);
    put_coin(3'b100);
    vif.mode_select = 1'b1;
    pulse_buy(2);
    settle();
    vif.mode_select = 1'b0;
    chk("t4_drain_products", n_prod, 15);
    chk("t4_drain_change", chg_q.size(), 3);
    clr_mon();
    put_coin(3'b011);
    pulse_buy(2);
    repeat (2) @(negedge clk);
    chk("t4_sold_out", n_sold, 1);
    chk("t4_balance_held", int'(vif.balance), 50);
    chk("t4_no_product", n_prod, 0);
    vif.sel = 2'd2; vif.restock = 1'b1; @(negedge clk); vif.restock = 1'b0;
    pulse_buy(2);
    repeat (3) @(negedge clk);
    chk("t4_restocked_product", n_prod, 1);
    chk("t4_balance_after", int'(vif.balance), 45);
    vif.refund = 1'b1; @(negedge clk); vif.refund = 1'b0;
    settle();

    // 5: rejects at the limit, invalid code, and during payout
    clr_mon();
    put_coin(3'b101); put_coin(3'b101);
    put_coin(3'b001);
    put_coin(3'b111);
    chk("t5_rejects", n_rej, 2);
    chk("t5_balance", int'(vif.balance), 1000);
    vif.refund = 1'b1; @(negedge clk); vif.refund = 1'b0;
    put_coin(3'b010);
    settle();
    chk("t5_payout_reject", n_rej, 3);
    chk("t5_change_count", chg_q.size(), 2);
    if (chg_q.size() > 0) chk("t5_change0", chg_q[0], 5);

    // 6: reset mid-payout clears everything at once
    put_coin(3'b011); put_coin(3'b010); put_coin(3'b001);
    vif.refund = 1'b1;
    @(posedge clk); #2;
    chk("t6_payout_balance", int'(vif.balance), 65);
    chk("t6_busy", int'(vif.busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_balance", int'(vif.balance), 0);
    chk("t6_rst_busy", int'(vif.busy), 0);
    chk("t6_rst_refund", int'(vif.refund_signal), 0);
    chk("t6_rst_change_valid", int'(vif.change_valid), 0);
    chk("t6_rst_change_coin", int'(vif.change_coin), 0);
    chk("t6_rst_pulses", int'({vif.product, vif.sold_out, vif.coin_reject}), 0);
    @(negedge clk); vif.refund = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    clr_mon();
    put_coin(3'b100);
    pulse_buy(2);
    settle();
    chk("t6_post_reset_product", n_prod, 1);
    chk("t6_post_reset_price", int'(vif.balance), 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      vif.coin = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      vif.sel = 2'($urandom_range(0, NS - 1));
      vif.buy = ($urandom_range(0, 3) == 0);
      vif.refund = ($urandom_range(0, 24) == 0);
      vif.mode_select = 1'($urandom_range(0, 1));
      vif.price_wr = ($urandom_range(0, 7) == 0);
      vif.price_val = ($urandom_range(0, 4) == 0) ? BW'($urandom_range(0, 1100))
                                                  : BW'(5 * $urandom_range(0, 210));
      vif.restock = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    idle_inputs();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_cycle_budget", (cyc < 90000) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
